// File: rtl/tri_tile_dispatch.sv
// tri_tile_dispatch
//   Front end of the tile rasterizer. Takes one screen-space triangle at a time,
//   computes its pixel bounding box clamped to the screen and issues one
//   transaction per covered tile in raster order (x fastest). Triangles wholly
//   off-screen are dropped without producing any transaction.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   tri_vld/tri_rdy   upstream triangle handshake (tri_rdy high only in IDLE)
//   tri_v0..tri_v2    packed {x,y,z}, signed fixed point (FRAC_BITS fraction)
//   tri_color         triangle colour
//   out_vld/out_rdy   rasterizer handshake
//   out_v0..out_v2    registered vertices, out_color registered colour
//   out_tile_x/_y     tile coordinates of the current transaction
//   out_last          final tile of the current triangle
//   busy              dispatcher is not idle
module tri_tile_dispatch #(
   parameter int COORD_W   = 16,
   parameter int FRAC_BITS = 4,
   parameter int TILE_W    = 16,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tri_vld,
   input  logic [3*COORD_W-1:0] tri_v0,
   input  logic [3*COORD_W-1:0] tri_v1,
   input  logic [3*COORD_W-1:0] tri_v2,
   input  logic [3:0]           tri_color,
   output logic                 tri_rdy,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [3*COORD_W-1:0] out_v0,
   output logic [3*COORD_W-1:0] out_v1,
   output logic [3*COORD_W-1:0] out_v2,
   output logic [5:0]           out_tile_x,
   output logic [4:0]           out_tile_y,
   output logic [3:0]           out_color,
   output logic                 out_last,
   output logic                 busy
);

   localparam int TS   = $clog2(TILE_W);
   localparam int TX_W = 6;
   localparam int TY_W = 5;

   typedef logic signed [COORD_W-1:0] crd_t;

   typedef struct packed {
      logic [3*COORD_W-1:0] v0;
      logic [3*COORD_W-1:0] v1;
      logic [3*COORD_W-1:0] v2;
      logic [3:0]           color;
   } tri_t;

   typedef enum logic [1:0] {IDLE, BBOX, EMIT} state_t;

   localparam crd_t X_MAX = crd_t'(SCREEN_W - 1);
   localparam crd_t Y_MAX = crd_t'(SCREEN_H - 1);

   // Fixed point to pixel: arithmetic shift floors toward -inf.
   function automatic crd_t pix(input crd_t c);
      return c >>> FRAC_BITS;
   endfunction

   function automatic crd_t min3(input crd_t a, input crd_t b, input crd_t c);
      crd_t m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic crd_t max3(input crd_t a, input crd_t b, input crd_t c);
      crd_t m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   state_t            state, state_nxt;
   tri_t              tri_q;
   logic [TX_W-1:0]   tx0_q, tx1_q, cur_x;
   logic [TY_W-1:0]   ty1_q, cur_y;

   // ---------------- bounding box (evaluated in BBOX) ----------------
   crd_t px0, px1, px2, py0, py1, py2;
   crd_t min_x, max_x, min_y, max_y;
   crd_t cmin_x, cmax_x, cmin_y, cmax_y;
   logic cull;
   logic [TX_W-1:0] tx0_n, tx1_n;
   logic [TY_W-1:0] ty0_n, ty1_n;

   assign px0 = pix(tri_q.v0[3*COORD_W-1 -: COORD_W]);
   assign px1 = pix(tri_q.v1[3*COORD_W-1 -: COORD_W]);
   assign px2 = pix(tri_q.v2[3*COORD_W-1 -: COORD_W]);
   assign py0 = pix(tri_q.v0[2*COORD_W-1 -: COORD_W]);
   assign py1 = pix(tri_q.v1[2*COORD_W-1 -: COORD_W]);
   assign py2 = pix(tri_q.v2[2*COORD_W-1 -: COORD_W]);

   assign min_x = min3(px0, px1, px2);
   assign max_x = max3(px0, px1, px2);
   assign min_y = min3(py0, py1, py2);
   assign max_y = max3(py0, py1, py2);

   // Sign bit stands in for "< 0" so the compare can never go unsigned.
   assign cull = max_x[COORD_W-1] || (min_x > X_MAX) ||
                 max_y[COORD_W-1] || (min_y > Y_MAX);

   // A surviving box always overlaps the screen, so only one side of
   // each bound can be out of range.
   assign cmin_x = min_x[COORD_W-1] ? '0 : min_x;
   assign cmin_y = min_y[COORD_W-1] ? '0 : min_y;
   assign cmax_x = (max_x > X_MAX) ? X_MAX : max_x;
   assign cmax_y = (max_y > Y_MAX) ? Y_MAX : max_y;

   // Clamped values are non-negative, so a logical shift is safe.
   assign tx0_n = TX_W'(cmin_x >> TS);
   assign tx1_n = TX_W'(cmax_x >> TS);
   assign ty0_n = TY_W'(cmin_y >> TS);
   assign ty1_n = TY_W'(cmax_y >> TS);

   // ---------------- control ----------------
   logic at_end, hs;

   assign at_end = (cur_x == tx1_q) && (cur_y == ty1_q);
   assign hs     = out_vld && out_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tri_vld) state_nxt = BBOX;
         BBOX:    state_nxt = cull ? IDLE : EMIT;
         EMIT:    if (hs && at_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tri_q <= '0;
         tx0_q <= '0;
         tx1_q <= '0;
         ty1_q <= '0;
         cur_x <= '0;
         cur_y <= '0;
      end else begin
         case (state)
            IDLE: if (tri_vld) tri_q <= '{v0: tri_v0, v1: tri_v1, v2: tri_v2, color: tri_color};
            BBOX: if (!cull) begin
               tx0_q <= tx0_n;
               tx1_q <= tx1_n;
               ty1_q <= ty1_n;
               cur_x <= tx0_n;
               cur_y <= ty0_n;
            end
            EMIT: if (hs && !at_end) begin
               if (cur_x == tx1_q) begin
                  cur_x <= tx0_q;
                  cur_y <= cur_y + 1'b1;
               end else begin
                  cur_x <= cur_x + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode straight from registers, so reset takes effect
   // without a clock and the payload is stable while stalled.
   assign tri_rdy    = (state == IDLE);
   assign out_vld    = (state == EMIT);
   assign busy       = (state != IDLE);
   assign out_last   = out_vld && at_end;
   assign out_v0     = tri_q.v0;
   assign out_v1     = tri_q.v1;
   assign out_v2     = tri_q.v2;
   assign out_color  = tri_q.color;
   assign out_tile_x = cur_x;
   assign out_tile_y = cur_y;

endmodule

// File: tb/tb_tri_tile_dispatch.sv
// Directed bench for tri_tile_dispatch. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_tri_tile_dispatch;

   logic        clk = 1'b0;
   logic        rst_n, tri_vld, out_rdy;
   logic [47:0] tri_v0, tri_v1, tri_v2;
   logic [3:0]  tri_color;
   logic        tri_rdy, out_vld, out_last, busy;
   logic [47:0] out_v0, out_v1, out_v2;
   logic [5:0]  out_tile_x;
   logic [4:0]  out_tile_y;
   logic [3:0]  out_color;

   int n_vec = 0;
   int n_err = 0;

   tri_tile_dispatch dut (
      .clk(clk), .rst_n(rst_n),
      .tri_vld(tri_vld), .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2),
      .tri_color(tri_color), .tri_rdy(tri_rdy),
      .out_vld(out_vld), .out_rdy(out_rdy),
      .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2),
      .out_tile_x(out_tile_x), .out_tile_y(out_tile_y),
      .out_color(out_color), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] mkr(input int xr, input int yr);
      return {16'(xr), 16'(yr), 16'(xr + yr + 3)};
   endfunction

   function automatic logic [47:0] mkv(input int x, input int y);
      return mkr(x * 16, y * 16);
   endfunction

   // {vld, tile_x, tile_y, last}
   function automatic logic [12:0] tile_exp(input int x, input int y, input logic l);
      return {1'b1, 6'(x), 5'(y), l};
   endfunction

   function automatic logic [12:0] tile_obs();
      return {out_vld, out_tile_x, out_tile_y, out_last};
   endfunction

   // Present a triangle for one cycle; returns in cycle N+1.
   task automatic send(input logic [47:0] a, input logic [47:0] b, input logic [47:0] c,
                       input logic [3:0] col);
      tri_v0 = a; tri_v1 = b; tri_v2 = c; tri_color = col;
      tri_vld = 1'b1;
      step();
      tri_vld = 1'b0;
   endtask

   // Consume tiles until the last one handshakes, checking raster order
   // against an independent cursor. Returns in the cycle after the last.
   task automatic drain(input int bound, input int tx0, input int tx1, input int ty0,
                        input int ty1, output int nhs, output int bad, output logic tmo,
                        output logic [12:0] lst);
      int ex, ey;
      ex = tx0; ey = ty0; nhs = 0; bad = 0; tmo = 1'b1; lst = '0;
      for (int c = 0; c < bound; c++) begin
         if (out_vld && out_rdy) begin
            if (int'(out_tile_x) != ex || int'(out_tile_y) != ey ||
                out_last !== (ex == tx1 && ey == ty1)) bad++;
            nhs++;
            if (out_last) begin
               lst = tile_obs();
               step();
               tmo = 1'b0;
               break;
            end
            if (ex == tx1) begin ex = tx0; ey++; end
            else ex++;
         end
         step();
      end
   endtask

   initial begin
      int nhs, bad;
      logic tmo;
      logic [12:0] lst;

      rst_n = 1'b0; tri_vld = 1'b0; out_rdy = 1'b0;
      tri_v0 = '0; tri_v1 = '0; tri_v2 = '0; tri_color = '0;
      step();
      chk("rst_tri_rdy",  64'(tri_rdy),  64'(1));
      chk("rst_out_vld",  64'(out_vld),  64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_busy",     64'(busy),     64'(0));
      chk("rst_payload",  64'({out_v0, out_color, out_tile_x, out_tile_y}), 64'(0));
      rst_n = 1'b1;
      step();

      // 2x2 tiles, full throughput
      out_rdy = 1'b1;
      send(mkv(10, 10), mkv(20, 10), mkv(10, 20), 4'd5);
      chk("t1_n1_tri_rdy", 64'(tri_rdy), 64'(0));
      chk("t1_n1_out_vld", 64'(out_vld), 64'(0));
      chk("t1_n1_busy",    64'(busy),    64'(1));
      step();
      chk("t1_n2_tile",  64'(tile_obs()), 64'(tile_exp(0, 0, 1'b0)));
      chk("t1_n2_color", 64'(out_color),  64'(5));
      chk("t1_n2_rdy",   64'(tri_rdy),    64'(0));
      step();
      chk("t1_n3_tile", 64'(tile_obs()), 64'(tile_exp(1, 0, 1'b0)));
      step();
      chk("t1_n4_tile", 64'(tile_obs()), 64'(tile_exp(0, 1, 1'b0)));
      step();
      chk("t1_n5_tile", 64'(tile_obs()), 64'(tile_exp(1, 1, 1'b1)));
      step();
      chk("t1_n6_out_vld", 64'(out_vld), 64'(0));
      chk("t1_n6_tri_rdy", 64'(tri_rdy), 64'(1));

      // Same triangle with back-pressure N+2..N+4
      out_rdy = 1'b0;
      send(mkv(10, 10), mkv(20, 10), mkv(10, 20), 4'd5);
      step();
      chk("t2_n2_tile", 64'(tile_obs()), 64'(tile_exp(0, 0, 1'b0)));
      chk("t2_n2_v0",   64'(out_v0),     64'(mkv(10, 10)));
      step();
      chk("t2_n3_tile", 64'(tile_obs()), 64'(tile_exp(0, 0, 1'b0)));
      step();
      chk("t2_n4_tile", 64'(tile_obs()), 64'(tile_exp(0, 0, 1'b0)));
      chk("t2_n4_v1",   64'(out_v1),     64'(mkv(20, 10)));
      step();
      out_rdy = 1'b1;
      drain(10, 0, 1, 0, 1, nhs, bad, tmo, lst);
      chk("t2_handshakes", 64'(nhs), 64'(4));
      chk("t2_order",      64'(bad), 64'(0));
      chk("t2_timeout",    64'(tmo), 64'(0));
      chk("t2_tri_rdy",    64'(tri_rdy), 64'(1));

      // Full-screen coverage with clamping on both x sides
      send(mkv(-50, 5), mkv(700, 5), mkv(5, 470), 4'd9);
      step();
      chk("t3_first", 64'(tile_obs()), 64'(tile_exp(0, 0, 1'b0)));
      drain(1300, 0, 39, 0, 29, nhs, bad, tmo, lst);
      chk("t3_handshakes", 64'(nhs), 64'(1200));
      chk("t3_order",      64'(bad), 64'(0));
      chk("t3_timeout",    64'(tmo), 64'(0));
      chk("t3_last",       64'(lst), 64'(tile_exp(39, 29, 1'b1)));
      chk("t3_idle",       64'({out_vld, tri_rdy}), 64'(2'b01));

      // Cull: right of screen
      send(mkv(640, 10), mkv(700, 20), mkv(650, 30), 4'd3);
      chk("t4_n1_tri_rdy", 64'(tri_rdy), 64'(0));
      chk("t4_n1_out_vld", 64'(out_vld), 64'(0));
      step();
      chk("t4_n2_tri_rdy", 64'(tri_rdy), 64'(1));
      chk("t4_n2_out_vld", 64'(out_vld), 64'(0));
      chk("t4_n2_busy",    64'(busy),    64'(0));

      // Cull: y slightly negative (fractions floor to -1)
      send(mkr(100, -1), mkr(200, -8), mkr(300, -15), 4'd3);
      step();
      chk("t4b_out_vld", 64'(out_vld), 64'(0));
      chk("t4b_tri_rdy", 64'(tri_rdy), 64'(1));

      // Boundary: min corner exactly on the last pixel is kept
      send(mkv(639, 479), mkv(700, 500), mkv(650, 490), 4'd7);
      step();
      drain(5, 39, 39, 29, 29, nhs, bad, tmo, lst);
      chk("t4c_handshakes", 64'(nhs), 64'(1));
      chk("t4c_last",       64'(lst), 64'(tile_exp(39, 29, 1'b1)));

      // Single tile with payload check
      send(mkv(33, 49), mkv(40, 49), mkv(33, 60), 4'hA);
      step();
      chk("t5_tile",  64'(tile_obs()), 64'(tile_exp(2, 3, 1'b1)));
      chk("t5_color", 64'(out_color),  64'(4'hA));
      chk("t5_v0",    64'(out_v0),     64'(mkv(33, 49)));
      chk("t5_v1",    64'(out_v1),     64'(mkv(40, 49)));
      chk("t5_v2",    64'(out_v2),     64'(mkv(33, 60)));
      step();
      chk("t5_done", 64'({out_vld, tri_rdy}), 64'(2'b01));

      // Asynchronous reset in the middle of EMIT
      send(mkv(10, 10), mkv(20, 10), mkv(10, 20), 4'd5);
      step();
      step();
      chk("t6_tile2", 64'(tile_obs()), 64'(tile_exp(1, 0, 1'b0)));
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_vld", 64'(out_vld),  64'(0));
      chk("t6_rst_tri_rdy", 64'(tri_rdy),  64'(1));
      chk("t6_rst_busy",    64'(busy),     64'(0));
      chk("t6_rst_last",    64'(out_last), 64'(0));
      #2;
      rst_n = 1'b1;
      step();
      send(mkv(33, 49), mkv(40, 49), mkv(33, 60), 4'hA);
      step();
      chk("t6_new_tile", 64'(tile_obs()), 64'(tile_exp(2, 3, 1'b1)));
      step();
      chk("t6_new_done", 64'({out_vld, tri_rdy}), 64'(2'b01));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tri_tile_dispatch.md
Name: tri_tile_dispatch

Overview:
- Front-end transmitter for the tile rasterizer. Accepts one screen-space triangle at a time and computes its pixel bounding box, clamped to the 640x480 screen.
- Issues one transaction per covered 16x16 tile in raster order (x fastest) over the rasterizer's vld/rdy input handshake.
- Each transaction carries the three vertices, the tile coordinates and the triangle colour. Triangles that lie wholly off-screen are culled and produce no transactions.

Parameters:
- COORD_W, 16: fixed-point coordinate width, signed 12.4.
- FRAC_BITS, 4: fractional bits per coordinate.
- TILE_W, 16: tile edge in pixels (power of two).
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tri_vld  in  1  upstream triangle valid
- tri_v0, tri_v1, tri_v2  in  3*COORD_W each  packed {x,y,z}, signed fixed point
- tri_color  in  4  triangle colour
- tri_rdy  out  1  dispatcher can accept a triangle
- out_vld  out  1  tile transaction valid (to rasterizer vld_in)
- out_rdy  in  1  rasterizer ready (rasterizer rdy_in)
- out_v0, out_v1, out_v2  out  3*COORD_W each  registered copy of the triangle's vertices
- out_tile_x  out  6  tile column, 0..SCREEN_W/TILE_W-1
- out_tile_y  out  5  tile row, 0..SCREEN_H/TILE_W-1
- out_color  out  4  registered triangle colour
- out_last  out  1  marks the final tile of the current triangle
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: asynchronous on rst_n low; all registers clear immediately. State=IDLE, tri_rdy=1, out_vld=0, out_last=0, busy=0, all payload outputs 0.
- Reset mid-operation discards the in-flight triangle; no partial completion.
- States: IDLE, BBOX, EMIT.
- IDLE:
  - tri_rdy=1.
  - On tri_vld&&tri_rdy (cycle N): register the vertices and colour, go to BBOX.
  - tri_rdy drops to 0 from N+1.
- BBOX (cycle N+1), single cycle:
  - Pixel coordinate p = coord >>> FRAC_BITS (arithmetic shift, truncates toward -inf).
  - min/max over the three vertices for x and y.
  - Cull if max_x<0, min_x>SCREEN_W-1, max_y<0 or min_y>SCREEN_H-1. On cull, return to IDLE; tri_rdy=1 at N+2 and no out_vld is issued.
  - Otherwise clamp min and max x into [0,SCREEN_W-1] and y into [0,SCREEN_H-1].
  - tx0=min_x/TILE_W, tx1=max_x/TILE_W, ty0, ty1 likewise (shifts).
  - Cursor = (tx0,ty0). Go to EMIT.
- EMIT:
  - out_vld=1 from N+2.
  - Payload is registered and must hold stable while out_vld&&!out_rdy.
  - out_last = (cursor_x==tx1 && cursor_y==ty1).
  - On out_vld&&out_rdy:
    - if last, go to IDLE; out_vld=0 and tri_rdy=1 next cycle.
    - else if cursor_x==tx1, cursor_x=tx0 and cursor_y++.
    - else cursor_x++.
  - Zero-bubble throughput: one tile per cycle while out_rdy=1.
- out_vld is never deasserted without a handshake. Payload never changes while out_vld=1 and out_rdy=0.
- tri_rdy and out_vld are never both 1.
- Degenerate (zero-area) triangles are not culled here; the rasterizer's edge test rejects them.
- Width rules: bbox arithmetic is done at COORD_W signed. Tile indices are taken after clamping, so they never exceed 39/29.

Test Plan:
- Verts pixel (10,10),(20,10),(10,20) (raw 160/320), colour 5, out_rdy=1. Accept at N: out_vld high N+2..N+5 with tiles (0,0),(1,0),(0,1),(1,1); out_last only at N+5; tri_rdy=1 at N+6.
- Same triangle with out_rdy low during N+2..N+4: tile (0,0) payload held stable; advances at N+5; 4 handshakes total.
- Verts (-50,5),(700,5),(5,470): 1200 transactions (tx 0..39, ty 0..29); first (0,0), last (39,29) with out_last=1.
- All vertices x>=640 (raw 10240+): no out_vld; tri_rdy=0 at N+1 and back to 1 at N+2.
- Triangle inside pixels (33..40, 49..60): exactly one transaction, tile (2,3), out_last=1, colour and vertices match the input.
- Assert rst_n low during EMIT at tile 2 of 4: out_vld=0 and tri_rdy=1 without waiting for clk. After release, a new triangle is accepted normally.
